mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start_mult  input  1  request signed multiply of a by b.
REQ-005 start_div  input  1  request signed divide of a by b.
REQ-006 a  input  32  operand A, two's complement (multiplicand or dividend).
REQ-007 b  input  32  operand B, two's complement (multiplier or divisor).
REQ-008 hi  output  32  HI result: product[63:32] or remainder; drives the HI register input.
REQ-009 lo  output  32  LO result: product[31:0] or quotient; drives the LO register input.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle pulse marking the update of hi/lo or div_zero.
REQ-012 div_zero  output  1  high when the last accepted divide had b == 0.

Function
REQ-013 SHALL implement the FSM states IDLE, MULT, DIV and DONE.
REQ-014 Starts SHALL be accepted only in IDLE; E0 denotes the accepting rising edge.
- a and b are captured at E0.
- start_mult and start_div high together: multiply wins; start_div is ignored.
REQ-015 Starts in MULT, DIV or DONE SHALL be ignored with no effect on state, operands or outputs.
REQ-016 MULT SHALL compute {hi,lo} = signed 64-bit a*b.
- Shift-add or Booth, one iteration per edge, 32 iterations, E1..E32.
REQ-017 DIV SHALL compute a signed divide by restoring or non-restoring division.
- One iteration per edge, 32 iterations, E1..E32.
- lo = quotient, truncated toward zero.
- hi = remainder, with the sign of the dividend.
REQ-018 Divide overflow: 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000 with no flag.
REQ-019 Cycle timing for a normal operation:
- busy rises at E0.
- At E33 hi/lo load the final result, busy falls, state goes to DONE and done rises.
- At E34 done falls and state returns to IDLE.
REQ-020 A start_div with b == 0 at E0 SHALL skip DIV.
- At E0: state goes to DONE, div_zero=1, done=1, busy stays 0, hi/lo unchanged.
- At E1: state returns to IDLE.
REQ-021 div_zero SHALL hold until the next accepted start, which clears it at that start's E0.
REQ-022 hi/lo SHALL hold their last result between operations; intermediate iterations are never visible on hi/lo.
REQ-023 An internal 6-bit iteration counter SHALL load 0 at E0, increment each iteration and end the operation at 32; no other wrap is permitted.

Reset
REQ-024 Asserting reset SHALL immediately, without waiting for clk, force:
- state=IDLE;
- hi=lo=0x00000000;
- busy=done=div_zero=0;
- counter and internal operand registers = 0.
REQ-025 Reset mid-operation SHALL abort the operation, and no done SHALL follow.
REQ-026 The first rising edge after reset deasserts SHALL be able to accept a start.

Verification
REQ-027 start_mult, a=7, b=0xFFFFFFFD (-3) -> at E33 hi=0xFFFFFFFF, lo=0xFFFFFFEB; done high exactly one cycle; busy high E0..E33.
REQ-028 start_div, a=0xFFFFFFF9 (-7), b=2 -> at E33 lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
REQ-029 Prior result hi=5, lo=9; start_div, a=100, b=0 -> at E0 done=1, div_zero=1, busy=0; hi=5, lo=9 unchanged.
REQ-030 start_div, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; also start_mult, a=b=0x80000000 -> hi=0x40000000, lo=0.
REQ-031 start_mult, a=3, b=4, with reset pulsed at E0+10 -> all outputs 0 immediately and no done appears; a new start_mult, a=2, b=2 -> lo=4, hi=0.
REQ-032 start_mult, a=6, b=7, then start_div pulsed at E0+5 and both starts held together at E0+33 -> lo=42, hi=0; the extra starts are ignored and the next operation is accepted only from IDLE at E34.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// -----------------------------------------------------------------------------
// mult_div_unit_if
// Bus between a requester and mult_div_unit.
//   start_mult/start_div/a/b : requester -> unit (request and operands)
//   hi/lo                    : unit -> requester (HI/LO results)
//   busy/done/div_zero       : unit -> requester (status)
//   dbg_state                : unit -> requester (FSM state, observation only)
// Handshake: a start is a level sampled on a rising edge; it is taken only
// while the unit is idle (busy low and done low). Taking it raises busy on
// that edge. Completion is a one-cycle done pulse in the cycle hi/lo (or
// div_zero) are updated; busy is already low in that cycle. Starts seen
// while not idle are dropped, never queued.
// -----------------------------------------------------------------------------
interface mult_div_unit_if;
  logic        start_mult;
  logic        start_div;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [1:0]  dbg_state;

  modport master (
    output start_mult, start_div, a, b,
    input  hi, lo, busy, done, div_zero, dbg_state
  );

  modport slave (
    input  start_mult, start_div, a, b,
    output hi, lo, busy, done, div_zero, dbg_state
  );
endinterface

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
// Iterative signed 32x32 multiply (64-bit result on hi:lo) and signed
// 32/32 divide (quotient on lo, remainder on hi), one iteration per clock,
// 32 iterations per operation.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high reset
//   bus    : mult_div_unit_if.slave (requests, operands, results, status)
// Both operations run on operand magnitudes and fix signs when the result
// is loaded, so hi/lo only ever change at the final edge.
// -----------------------------------------------------------------------------
module mult_div_unit (
  input  logic             clk,
  input  logic             reset,
  mult_div_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        div_zero_q, div_zero_d;
  logic [5:0]  cnt_q, cnt_d;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [63:0] acc_q, acc_d;
  // Magnitude of the multiplicand or of the divisor.
  logic [31:0] opb_q, opb_d;
  // Sign of product/quotient, and sign of the remainder (dividend sign).
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;

  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic [63:0] prod_res;
  logic [31:0] quo_res;
  logic [31:0] rem_res;

  function automatic logic [31:0] mag(input logic [31:0] x);
    // 0x80000000 maps to itself, which is its correct unsigned magnitude.
    return x[31] ? (~x + 32'd1) : x;
  endfunction

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opb_d      = opb_q;
    neg_d      = neg_q;
    rneg_d     = rneg_q;

    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    div_shift = {acc_q[63:32], acc_q[31]};
    div_diff  = div_shift - {1'b0, opb_q};
    prod_res  = neg_q  ? (~acc_q + 64'd1)         : acc_q;
    quo_res   = neg_q  ? (~acc_q[31:0] + 32'd1)   : acc_q[31:0];
    rem_res   = rneg_q ? (~acc_q[63:32] + 32'd1)  : acc_q[63:32];

    case (state_q)
      IDLE: begin
        if (bus.start_mult) begin
          state_d    = MULT;
          busy_d     = 1'b1;
          div_zero_d = 1'b0;
          cnt_d      = 6'd0;
          opb_d      = mag(bus.a);
          acc_d      = {32'd0, mag(bus.b)};
          neg_d      = bus.a[31] ^ bus.b[31];
          rneg_d     = 1'b0;
        end else if (bus.start_div) begin
          cnt_d = 6'd0;
          if (bus.b == 32'd0) begin
            // Divide by zero never iterates; report it right away.
            state_d    = DONE;
            div_zero_d = 1'b1;
            done_d     = 1'b1;
            opb_d      = 32'd0;
            acc_d      = 64'd0;
            neg_d      = 1'b0;
            rneg_d     = 1'b0;
          end else begin
            state_d    = DIV;
            busy_d     = 1'b1;
            div_zero_d = 1'b0;
            opb_d      = mag(bus.b);
            acc_d      = {32'd0, mag(bus.a)};
            neg_d      = bus.a[31] ^ bus.b[31];
            rneg_d     = bus.a[31];
          end
        end
      end

      MULT: begin
        if (cnt_q == 6'd32) begin
          hi_d    = prod_res[63:32];
          lo_d    = prod_res[31:0];
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          // Shift-add: add multiplicand to the top half when the current
          // multiplier bit is set, then shift the whole accumulator right.
          acc_d = {mul_sum, acc_q[31:1]};
          cnt_d = cnt_q + 6'd1;
        end
      end

      DIV: begin
        if (cnt_q == 6'd32) begin
          hi_d    = rem_res;
          lo_d    = quo_res;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          // Restoring step: the trial subtract's borrow decides the
          // quotient bit and whether the shifted remainder is kept.
          if (!div_diff[32]) acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
          else               acc_d = {div_shift[31:0], acc_q[30:0], 1'b0};
          cnt_d = cnt_q + 6'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      cnt_q      <= 6'd0;
      acc_q      <= 64'd0;
      opb_q      <= 32'd0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opb_q      <= opb_d;
      neg_q      <= neg_d;
      rneg_q     <= rneg_d;
    end
  end

  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.div_zero  = div_zero_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
// Directed vectors with hand-computed results for mult_div_unit.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, i.e. just after the edge that produced them.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MULT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  mult_div_unit_if u_if ();

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_starts();
    u_if.start_mult = 1'b0;
    u_if.start_div  = 1'b0;
  endtask

  // Issue one operation and follow it to its done pulse (bounded).
  task automatic run_op(input logic is_mult, input logic [31:0] av, input logic [31:0] bv,
                        output int done_edge, output int busy_cnt);
    u_if.start_mult = is_mult;
    u_if.start_div  = ~is_mult;
    u_if.a = av;
    u_if.b = bv;
    tick();                              // E0
    clear_starts();
    u_if.a = 32'hDEAD_BEEF;              // operands must already be captured
    u_if.b = 32'h0BAD_F00D;
    busy_cnt  = u_if.busy ? 1 : 0;
    done_edge = -1;
    for (int e = 1; e <= 40 && done_edge < 0; e++) begin
      tick();
      if (u_if.busy) busy_cnt++;
      if (u_if.done) done_edge = e;
    end
  endtask

  task automatic do_op(input string tag, input logic is_mult, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int de, bc;
    run_op(is_mult, av, bv, de, bc);
    check({tag, "_done_edge"}, 64'(de), 64'd33);
    check({tag, "_busy_cycles"}, 64'(bc), 64'd33);
    check({tag, "_hi"}, {32'd0, u_if.hi}, {32'd0, exp_hi});
    check({tag, "_lo"}, {32'd0, u_if.lo}, {32'd0, exp_lo});
    tick();                              // E34
    check({tag, "_done_fall"}, {63'd0, u_if.done}, 64'd0);
    check({tag, "_idle"}, {62'd0, u_if.dbg_state}, {62'd0, ST_IDLE});
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic        is_mult;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  initial begin
    vec_t vecs[4];
    int de, ndone;

    clear_starts();
    u_if.a = 32'd0;
    u_if.b = 32'd0;

    // Reset takes effect without a clock edge.
    #2 reset = 1'b1;
    #1;
    check("rst_hi",       {32'd0, u_if.hi}, 64'd0);
    check("rst_lo",       {32'd0, u_if.lo}, 64'd0);
    check("rst_busy",     {63'd0, u_if.busy}, 64'd0);
    check("rst_done",     {63'd0, u_if.done}, 64'd0);
    check("rst_div_zero", {63'd0, u_if.div_zero}, 64'd0);
    check("rst_state",    {62'd0, u_if.dbg_state}, {62'd0, ST_IDLE});
    tick();
    tick();
    reset = 1'b0;

    // 7 * -3 = -21
    do_op("mul_7_m3", 1'b1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    // -7 / 2 = -3 rem -1
    do_op("div_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    vecs[0] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001}; // -1*-1
    vecs[1] = '{1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000}; // 2^16*2^16
    vecs[2] = '{1'b0, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD}; // 7/-2
    vecs[3] = '{1'b0, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002}; // -8/-3
    for (int i = 0; i < 4; i++)
      do_op($sformatf("vec%0d", i), vecs[i].is_mult, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // Leave hi=5, lo=9 (95 / 10), then divide by zero.
    do_op("div_95_10", 1'b0, 32'd95, 32'd10, 32'd5, 32'd9);
    u_if.start_div = 1'b1;
    u_if.a = 32'd100;
    u_if.b = 32'd0;
    tick();                              // E0
    clear_starts();
    check("dz_done",     {63'd0, u_if.done}, 64'd1);
    check("dz_flag",     {63'd0, u_if.div_zero}, 64'd1);
    check("dz_busy",     {63'd0, u_if.busy}, 64'd0);
    check("dz_hi",       {32'd0, u_if.hi}, 64'd5);
    check("dz_lo",       {32'd0, u_if.lo}, 64'd9);
    check("dz_state",    {62'd0, u_if.dbg_state}, {62'd0, ST_DONE});
    tick();                              // E1
    check("dz_idle",     {62'd0, u_if.dbg_state}, {62'd0, ST_IDLE});
    check("dz_done_fall",{63'd0, u_if.done}, 64'd0);
    check("dz_flag_hold",{63'd0, u_if.div_zero}, 64'd1);

    // Overflow divide; the accepted start also clears div_zero.
    do_op("div_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    check("ovf_dz_clear", {63'd0, u_if.div_zero}, 64'd0);
    do_op("mul_min_min", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);

    // Reset in the middle of a multiply.
    u_if.start_mult = 1'b1;
    u_if.a = 32'd3;
    u_if.b = 32'd4;
    tick();                              // E0
    clear_starts();
    for (int e = 1; e <= 10; e++) tick();
    #2 reset = 1'b1;
    #1;
    check("mid_rst_hi",    {32'd0, u_if.hi}, 64'd0);
    check("mid_rst_lo",    {32'd0, u_if.lo}, 64'd0);
    check("mid_rst_busy",  {63'd0, u_if.busy}, 64'd0);
    check("mid_rst_state", {62'd0, u_if.dbg_state}, {62'd0, ST_IDLE});
    tick();
    reset = 1'b0;
    ndone = 0;
    for (int e = 0; e < 40; e++) begin
      tick();
      if (u_if.done) ndone++;
    end
    check("mid_rst_no_done", 64'(ndone), 64'd0);

    // A start is taken on the first edge after reset falls.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    do_op("post_rst_mul", 1'b1, 32'd2, 32'd2, 32'd0, 32'd4);

    // Starts during MULT and DONE are ignored; IDLE accepts again.
    u_if.start_mult = 1'b1;
    u_if.a = 32'd6;
    u_if.b = 32'd7;
    tick();                              // E0
    clear_starts();
    u_if.a = 32'h1234;
    u_if.b = 32'd0;
    de = -1;
    for (int e = 1; e <= 35; e++) begin
      if (e == 5) u_if.start_div = 1'b1;
      if (e == 6) u_if.start_div = 1'b0;
      if (e == 33) begin
        u_if.start_mult = 1'b1;
        u_if.start_div  = 1'b1;
        u_if.a = 32'd1;
        u_if.b = 32'd1;
      end
      tick();
      if (u_if.done && de < 0) de = e;
      if (e == 33) begin
        check("ign_hi", {32'd0, u_if.hi}, 64'd0);
        check("ign_lo", {32'd0, u_if.lo}, 64'd42);
        check("ign_dz", {63'd0, u_if.div_zero}, 64'd0);
      end
      if (e == 34) begin
        check("ign_e34_state", {62'd0, u_if.dbg_state}, {62'd0, ST_IDLE});
        check("ign_e34_busy",  {63'd0, u_if.busy}, 64'd0);
      end
    end
    check("ign_done_edge", 64'(de), 64'd33);
    check("e35_accept_busy",  {63'd0, u_if.busy}, 64'd1);
    check("e35_accept_state", {62'd0, u_if.dbg_state}, {62'd0, ST_MULT});
    clear_starts();
    de = -1;
    for (int e = 1; e <= 40 && de < 0; e++) begin
      tick();
      if (u_if.done) de = e;
    end
    check("e35_done_edge", 64'(de), 64'd33);
    check("e35_hi", {32'd0, u_if.hi}, 64'd0);
    check("e35_lo", {32'd0, u_if.lo}, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
